// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART receiver
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int CLK_HZ       = 50000000;
    localparam int BAUD         = 115200;
    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int DATA_BITS    = 8;

    // 2-of-3 vote used when oversampled sample points are enabled
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - 2-flop synchroniser with falling-edge detect for an async input
module uart_rx_sync (
    input  logic clk,
    input  logic nRst,
    input  logic rx_i,
    output logic rx_s_o,
    output logic fall_o
);

    logic       meta_q;
    logic       rx_s_q;
    logic       rx_p_q;
    // Fills with ones after reset; edges are only trusted once every stage
    // holds a real sample, so a line already low at release is not an edge.
    logic [2:0] arm_q;

    // Synchroniser chain, previous-sample flop and arming shift register
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            meta_q <= 1'b1;
            rx_s_q <= 1'b1;
            rx_p_q <= 1'b1;
            arm_q  <= '0;
        end else begin
            meta_q <= rx_i;
            rx_s_q <= meta_q;
            rx_p_q <= rx_s_q;
            arm_q  <= {arm_q[1:0], 1'b1};
        end
    end

    assign rx_s_o = rx_s_q;
    assign fall_o = arm_q[2] & rx_p_q & ~rx_s_q;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver; optional majority-vote sampling via UART_RX_MAJORITY_EN
module uart_rx #(
    parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT,
    parameter int DATA_BITS    = uart_pkg::DATA_BITS
) (
    input  logic                 clk,
    input  logic                 nRst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 busy
);

    import uart_pkg::*;

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

`ifdef UART_RX_MAJORITY_EN
    // Votes are taken at target-1, target, target+1 and the decision lands at
    // target+1. Only the start point is delayed here; the in-frame counters
    // restart one cycle late, so their window already ends at the normal
    // target and the bit spacing stays CLKS_PER_BIT.
    localparam int START_LAST = CLKS_PER_BIT / 2;
`else
    localparam int START_LAST = CLKS_PER_BIT / 2 - 1;
`endif
    localparam int FULL_LAST  = CLKS_PER_BIT - 1;

    uart_state_e           state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic [DATA_BITS-1:0]  data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  ferr_q, ferr_d;

    logic                  rx_s;
    logic                  fall;
    logic [CNT_W-1:0]      last_cnt;
    logic                  sample_now;
    logic                  sample_bit;

    uart_rx_sync u_sync (
        .clk    (clk),
        .nRst   (nRst),
        .rx_i   (rx),
        .rx_s_o (rx_s),
        .fall_o (fall)
    );

    assign last_cnt   = (state_q == START) ? CNT_W'(START_LAST) : CNT_W'(FULL_LAST);
    assign sample_now = (cnt_q == last_cnt);

`ifdef UART_RX_MAJORITY_EN
    logic vote0_q;
    logic vote1_q;

    // Capture the two early votes ahead of the decision cycle
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            vote0_q <= 1'b1;
            vote1_q <= 1'b1;
        end else begin
            if (cnt_q == last_cnt - CNT_W'(2)) vote0_q <= rx_s;
            if (cnt_q == last_cnt - CNT_W'(1)) vote1_q <= rx_s;
        end
    end

    assign sample_bit = maj3(vote0_q, vote1_q, rx_s);
`else
    assign sample_bit = rx_s;
`endif

    // State, counters, shift register and registered outputs
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    // Frame sequencing; the counter is cleared on every sample and state change
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (fall) begin
                    state_d = START;
                end
            end
            START: begin
                if (sample_now) begin
                    cnt_d = '0;
                    if (!sample_bit) begin
                        state_d = DATA;
                        idx_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (sample_now) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = sample_bit;
                    if (idx_q == IDX_W'(DATA_BITS - 1)) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            STOP: begin
                if (sample_now) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (sample_bit) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != IDLE);

endmodule
